sfp_ctrl: RTL and testbench
===========================

Name: sfp_ctrl

Overview:
- Sequencer for the per-column special-function (SFP) stage sitting between the output FIFO, the PSUM SRAM and the SFP lanes.
- For one command, walks a contiguous range of PSUM SRAM rows and drives the SFP control lines (accum, act_func, passthrough).
- Issues the matching SRAM read/write and OFIFO pops, so each row is stored, accumulated, activated or read out.

Parameters:
- addr_bw, 11, PSUM SRAM address width.
- len_bw, 12, row-count width; must be at least addr_bw+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- mode  input  2  0=STORE (passthrough), 1=ACCUM, 2=ACT, 3=READ.
- leaky  input  1  ACT mode only: 1=leaky ReLU, 0=ReLU.
- base_addr  input  addr_bw  first row address.
- len  input  len_bw  number of rows to process.
- ofifo_valid  input  1  OFIFO holds a complete row.
- ofifo_rd  output  1  OFIFO pop, one pulse per consumed row.
- sram_cen  output  1  PSUM SRAM chip enable, active low.
- sram_wen  output  1  PSUM SRAM write enable, active low.
- sram_a  output  addr_bw  PSUM SRAM address.
- accum  output  1  to SFP lanes.
- act_func  output  2  to SFP lanes.
- passthrough  output  1  to SFP lanes.
- out_valid  output  1  READ mode: SRAM Q (through SFP) is valid this cycle.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE, sram_cen=1, sram_wen=1, sram_a=0, ofifo_rd=0, accum=0, act_func=0, passthrough=0, out_valid=0, busy=0, done=0.
- Reset mid-command aborts immediately. No done pulse. No further SRAM or OFIFO activity.
- All outputs are registered; counters are addr (addr_bw) and remaining (len_bw).
- IDLE:
  - start=1 latches mode, leaky, base_addr, len.
  - len=0: go to DONE with no SRAM/OFIFO activity.
  - Otherwise go to the mode's first state.
  - start is ignored while not in IDLE.
- Lane controls are held constant from the cycle after start through the last access; 0 in IDLE and DONE:
  - STORE: passthrough=1, accum=0, act_func=00.
  - ACCUM: passthrough=0, accum=1, act_func=00.
  - ACT: passthrough=0, accum=0, act_func={0,leaky}.
  - READ: passthrough=0, accum=0, act_func=10.
- STORE (state WR):
  - Each cycle with ofifo_valid=1: sram_cen=0, sram_wen=0, sram_a=addr, ofifo_rd=1; addr++, remaining--.
  - ofifo_valid=0: cen=1, no pop (stall).
  - Throughput: 1 row/cycle.
- ACCUM (states RD, WR):
  - RD: cen=0, wen=1, sram_a=addr, then go to WR.
  - WR: waits for ofifo_valid with cen=1 (SRAM Q is held while idle). When ofifo_valid=1: cen=0, wen=0, same address, ofifo_rd=1; addr++, remaining--; back to RD.
  - Minimum 2 cycles/row.
- ACT (states RD, WR): same as ACCUM but never waits on or pops the OFIFO; exactly 2 cycles/row.
- READ (state RD):
  - Reads consecutive addresses at 1 row/cycle.
  - out_valid=1 exactly one cycle after each read.
  - Final out_valid occurs in DONE.
- Last row: when remaining reaches 0 after an access, go to DONE.
- DONE: done=1 for one cycle, all SRAM/OFIFO controls inactive, then IDLE.
- busy=1 in every state except IDLE and DONE.
- Address arithmetic wraps modulo 2^addr_bw, e.g. base_addr=2047, len=2 accesses 2047 then 0.
- sram_wen=1 whenever sram_cen=1.
- A write and a pop are issued only in the same cycle, never separately.

Test Plan:
- Reset, then STORE base=0x010 len=3 with ofifo_valid=1 throughout -> writes at 0x010, 0x011, 0x012 on 3 consecutive cycles, 3 ofifo_rd pulses, passthrough=1, done on the 4th cycle.
- ACCUM base=0x100 len=2, ofifo_valid low for 3 cycles after the first read -> read 0x100, cen=1 stall for 3 cycles, write 0x100 with pop; then read/write 0x101; exactly 2 pops, accum=1 throughout.
- ACT leaky=1 base=0x020 len=4 -> act_func=01, 8 SRAM accesses alternating R/W, ofifo_rd never asserted, done 9 cycles after start.
- READ base=2046 len=3 -> reads 2046, 2047, 0; out_valid on the 3 following cycles; act_func=10.
- len=0 with start -> done pulse the cycle after start, sram_cen stays 1; a start asserted while busy produces no second command.
- reset_n=0 during an ACCUM WR stall -> next cycle all outputs at reset values, no done, and a fresh STORE command works correctly.

Source files
------------

// File: rtl/sfp_ctrl.sv
// SFP stage sequencer: walks a PSUM SRAM row range per command and drives
// the SFP lane controls, SRAM strobes and OFIFO pops with registered outputs.
module sfp_ctrl #(
    parameter int addr_bw = 11,
    parameter int len_bw  = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               leaky,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [len_bw-1:0]  len,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               sram_cen,
    output logic               sram_wen,
    output logic [addr_bw-1:0] sram_a,
    output logic               accum,
    output logic [1:0]         act_func,
    output logic               passthrough,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    localparam logic [1:0] M_STORE = 2'd0;
    localparam logic [1:0] M_ACCUM = 2'd1;
    localparam logic [1:0] M_ACT   = 2'd2;
    localparam logic [1:0] M_READ  = 2'd3;

    state_t             r_state, w_state_nx;
    logic [1:0]         r_mode, w_mode_nx, w_mode_eff;
    logic [addr_bw-1:0] r_addr, w_addr_nx, w_acc_addr;
    logic [addr_bw-1:0] r_sram_a, w_sram_a;
    logic [len_bw-1:0]  r_rem, w_rem_nx, w_acc_rem;
    logic               r_cen, w_cen;
    logic               r_wen, w_wen;
    logic               r_pop, w_pop;
    logic               r_accum, w_accum;
    logic [1:0]         r_act, w_act;
    logic               r_pass, w_pass;
    logic               r_ov, w_ov;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               w_fin, w_do_rd, w_do_wr, w_adv;

    // In IDLE the access uses the command inputs directly, later the counters.
    assign w_mode_eff = (r_state == S_IDLE) ? mode : r_mode;
    assign w_acc_addr = (r_state == S_IDLE) ? base_addr : r_addr;
    assign w_acc_rem  = (r_state == S_IDLE) ? len : r_rem;

    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_addr_nx  = r_addr;
        w_rem_nx   = r_rem;
        w_fin      = 1'b0;
        w_do_rd    = 1'b0;
        w_do_wr    = 1'b0;
        w_ov       = 1'b0;
        w_accum    = r_accum;
        w_act      = r_act;
        w_pass     = r_pass;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode_nx = mode;
                    if (len == '0) begin
                        w_fin = 1'b1;
                    end else begin
                        w_addr_nx = base_addr;
                        w_rem_nx  = len;
                        w_pass    = (mode == M_STORE);
                        w_accum   = (mode == M_ACCUM);
                        unique case (mode)
                            M_ACT:   w_act = {1'b0, leaky};
                            M_READ:  w_act = 2'b10;
                            default: w_act = 2'b00;
                        endcase
                        if (mode == M_STORE) begin
                            w_state_nx = S_WR;
                            w_do_wr    = ofifo_valid;
                        end else begin
                            w_state_nx = S_RD;
                            w_do_rd    = 1'b1;
                        end
                    end
                end
            end
            S_RD: begin
                if (r_mode == M_READ) begin
                    w_ov = 1'b1;
                    if (r_rem == '0) w_fin = 1'b1;
                    else w_do_rd = 1'b1;
                end else begin
                    w_state_nx = S_WR;
                    w_do_wr    = (r_mode == M_ACT) || ofifo_valid;
                end
            end
            S_WR: begin
                // r_cen low here means this cycle carried the row's write.
                if (r_rem == '0) begin
                    w_fin = 1'b1;
                end else if (r_mode != M_STORE && !r_cen) begin
                    w_state_nx = S_RD;
                    w_do_rd    = 1'b1;
                end else begin
                    w_do_wr = (r_mode == M_ACT) || ofifo_valid;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_adv = w_do_wr || (w_do_rd && w_mode_eff == M_READ);
        if (w_adv) begin
            w_addr_nx = w_acc_addr + 1'b1;
            w_rem_nx  = w_acc_rem - 1'b1;
        end
        if (w_fin) begin
            w_state_nx = S_DONE;
            w_accum    = 1'b0;
            w_act      = 2'b00;
            w_pass     = 1'b0;
        end

        w_cen    = !(w_do_rd || w_do_wr);
        w_wen    = !w_do_wr;
        w_pop    = w_do_wr && (w_mode_eff != M_ACT);
        w_sram_a = w_cen ? r_sram_a : w_acc_addr;
        w_done   = w_fin;
        w_busy   = (w_state_nx == S_RD) || (w_state_nx == S_WR);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_mode   <= M_STORE;
            r_addr   <= '0;
            r_rem    <= '0;
            r_sram_a <= '0;
            r_cen    <= 1'b1;
            r_wen    <= 1'b1;
            r_pop    <= 1'b0;
            r_accum  <= 1'b0;
            r_act    <= 2'b00;
            r_pass   <= 1'b0;
            r_ov     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_mode   <= w_mode_nx;
            r_addr   <= w_addr_nx;
            r_rem    <= w_rem_nx;
            r_sram_a <= w_sram_a;
            r_cen    <= w_cen;
            r_wen    <= w_wen;
            r_pop    <= w_pop;
            r_accum  <= w_accum;
            r_act    <= w_act;
            r_pass   <= w_pass;
            r_ov     <= w_ov;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign ofifo_rd    = r_pop;
    assign sram_cen    = r_cen;
    assign sram_wen    = r_wen;
    assign sram_a      = r_sram_a;
    assign accum       = r_accum;
    assign act_func    = r_act;
    assign passthrough = r_pass;
    assign out_valid   = r_ov;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl: each cycle's outputs checked against
// hand-derived expectations on the falling clock edge.
module tb_sfp_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  mode;
    logic        leaky;
    logic [10:0] base_addr;
    logic [11:0] len;
    logic        ofifo_valid;
    logic        ofifo_rd;
    logic        sram_cen;
    logic        sram_wen;
    logic [10:0] sram_a;
    logic        accum;
    logic [1:0]  act_func;
    logic        passthrough;
    logic        out_valid;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sfp_ctrl #(.addr_bw(11), .len_bw(12)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .mode(mode),
        .leaky(leaky),
        .base_addr(base_addr),
        .len(len),
        .ofifo_valid(ofifo_valid),
        .ofifo_rd(ofifo_rd),
        .sram_cen(sram_cen),
        .sram_wen(sram_wen),
        .sram_a(sram_a),
        .accum(accum),
        .act_func(act_func),
        .passthrough(passthrough),
        .out_valid(out_valid),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Address is only compared on cycles where the SRAM is enabled.
    task automatic cyc(input string tag, input logic e_cen, input logic e_wen,
                       input logic [10:0] e_a, input logic e_rd,
                       input logic e_acc, input logic [1:0] e_act,
                       input logic e_pass, input logic e_ov,
                       input logic e_busy, input logic e_done);
        logic [20:0] g;
        logic [20:0] e;
        @(negedge clk);
        g = {sram_cen, sram_wen, (e_cen ? 11'h0 : sram_a), ofifo_rd, accum,
             act_func, passthrough, out_valid, busy, done};
        e = {e_cen, e_wen, (e_cen ? 11'h0 : e_a), e_rd, e_acc,
             e_act, e_pass, e_ov, e_busy, e_done};
        chk(tag, {11'h0, g}, {11'h0, e});
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        mode        = 2'd0;
        leaky       = 1'b0;
        base_addr   = 11'h0;
        len         = 12'h0;
        ofifo_valid = 1'b0;
        @(negedge clk);
        cyc("rst", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("rst_a", {21'h0, sram_a}, 32'h0);
        reset_n = 1'b1;
        cyc("idle0", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // STORE 0x010, 3 rows, OFIFO always valid
        start = 1; mode = 2'd0; base_addr = 11'h010; len = 12'd3;
        ofifo_valid = 1;
        cyc("st_w0", 0, 0, 11'h010, 1, 0, 2'b00, 1, 0, 1, 0);
        start = 0;
        cyc("st_w1", 0, 0, 11'h011, 1, 0, 2'b00, 1, 0, 1, 0);
        cyc("st_w2", 0, 0, 11'h012, 1, 0, 2'b00, 1, 0, 1, 0);
        ofifo_valid = 0;
        cyc("st_done", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        cyc("st_idle", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // ACCUM 0x100, 2 rows, OFIFO empty for 3 cycles after first read
        start = 1; mode = 2'd1; base_addr = 11'h100; len = 12'd2;
        cyc("ac_r0", 0, 1, 11'h100, 0, 1, 2'b00, 0, 0, 1, 0);
        start = 0;
        cyc("ac_s0", 1, 1, 0, 0, 1, 2'b00, 0, 0, 1, 0);
        cyc("ac_s1", 1, 1, 0, 0, 1, 2'b00, 0, 0, 1, 0);
        cyc("ac_s2", 1, 1, 0, 0, 1, 2'b00, 0, 0, 1, 0);
        ofifo_valid = 1;
        cyc("ac_w0", 0, 0, 11'h100, 1, 1, 2'b00, 0, 0, 1, 0);
        cyc("ac_r1", 0, 1, 11'h101, 0, 1, 2'b00, 0, 0, 1, 0);
        cyc("ac_w1", 0, 0, 11'h101, 1, 1, 2'b00, 0, 0, 1, 0);
        ofifo_valid = 0;
        cyc("ac_done", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        cyc("ac_idle", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // ACT leaky 0x020, 4 rows; OFIFO valid must not cause pops,
        // and a start pulse while busy must be ignored
        start = 1; mode = 2'd2; leaky = 1; base_addr = 11'h020; len = 12'd4;
        ofifo_valid = 1;
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("act_r%0d", i), 0, 1, 11'(32'h20 + i),
                0, 0, 2'b01, 0, 0, 1, 0);
            if (i == 0) begin
                start = 0; leaky = 0;
            end
            cyc($sformatf("act_w%0d", i), 0, 0, 11'(32'h20 + i),
                0, 0, 2'b01, 0, 0, 1, 0);
            if (i == 0) begin
                start = 1; mode = 2'd3; base_addr = 11'h3AA; len = 12'd5;
            end
            if (i == 1) start = 0;
        end
        ofifo_valid = 0;
        cyc("act_done", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        cyc("act_idle0", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        cyc("act_idle1", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // READ 2046, 3 rows, wraps to 0
        start = 1; mode = 2'd3; base_addr = 11'd2046; len = 12'd3;
        cyc("rd_r0", 0, 1, 11'd2046, 0, 0, 2'b10, 0, 0, 1, 0);
        start = 0;
        cyc("rd_r1", 0, 1, 11'd2047, 0, 0, 2'b10, 0, 1, 1, 0);
        cyc("rd_r2", 0, 1, 11'd0, 0, 0, 2'b10, 0, 1, 1, 0);
        cyc("rd_done", 1, 1, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        cyc("rd_idle", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // len = 0: immediate done, no SRAM or OFIFO activity
        start = 1; mode = 2'd1; base_addr = 11'h055; len = 12'd0;
        ofifo_valid = 1;
        cyc("z_done", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        start = 0;
        cyc("z_idle", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        ofifo_valid = 0;

        // Reset during an ACCUM write stall, then a fresh wrapping STORE
        start = 1; mode = 2'd1; base_addr = 11'h200; len = 12'd3;
        cyc("ra_r0", 0, 1, 11'h200, 0, 1, 2'b00, 0, 0, 1, 0);
        start = 0;
        cyc("ra_s0", 1, 1, 0, 0, 1, 2'b00, 0, 0, 1, 0);
        reset_n = 0;
        cyc("ra_rst", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("ra_rst_a", {21'h0, sram_a}, 32'h0);
        reset_n = 1;
        ofifo_valid = 1;
        cyc("ra_nodone", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        start = 1; mode = 2'd0; base_addr = 11'h7FF; len = 12'd2;
        cyc("rs_w0", 0, 0, 11'h7FF, 1, 0, 2'b00, 1, 0, 1, 0);
        start = 0;
        cyc("rs_w1", 0, 0, 11'h000, 1, 0, 2'b00, 1, 0, 1, 0);
        ofifo_valid = 0;
        cyc("rs_done", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        cyc("rs_idle", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
